// File: rtl/store_queue_pkg.sv
// Store queue shared types: machine widths, LSU op encoding,
// entry layout and op-size to byte-mask helper.
package store_queue_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned PLEN = 32;
   localparam int unsigned NB   = XLEN / 8;
   localparam int unsigned OFFW = $clog2(NB);
   localparam int unsigned WAW  = PLEN - OFFW;

   // op[1:0] is log2 of the access size in bytes
   typedef enum logic [2:0] {
      LSU_LB = 3'b000,
      LSU_LH = 3'b001,
      LSU_LW = 3'b010,
      LSU_LD = 3'b011,
      LSU_SB = 3'b100,
      LSU_SH = 3'b101,
      LSU_SW = 3'b110,
      LSU_SD = 3'b111
   } lsu_op_e;

   typedef struct packed {
      logic            valid;
      logic            committed;
      logic            ready;
      logic [WAW-1:0]  waddr;
      logic [NB-1:0]   mask;
      logic [XLEN-1:0] data;
   } sq_entry_t;

   function automatic logic [NB-1:0] op_mask(
      input lsu_op_e         op,
      input logic [OFFW-1:0] off
   );
      logic [NB-1:0] m;
      m = '0;
      unique case (op[1:0])
         2'd0: m = NB'(1);
         2'd1: m = NB'(3);
         2'd2: m = NB'(15);
         2'd3: m = NB'(255);
      endcase
      return m << off;
   endfunction

endpackage

// File: rtl/store_queue_byte_fwd.sv
// One load byte lane: picks the youngest candidate entry by
// scanning oldest (head) to youngest, last match wins.
module sq_byte_fwd
   import store_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned IDW   = $clog2(DEPTH)
) (
   input  logic [IDW-1:0]     head_i,
   input  logic [DEPTH-1:0]   cand_i,
   input  logic [DEPTH*8-1:0] data_i,
   output logic               hit_o,
   output logic [7:0]         byte_o
);

   logic [IDW-1:0] idx;

   always_comb begin
      hit_o  = 1'b0;
      byte_o = '0;
      idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i + IDW'(k);
         if (cand_i[idx]) begin
            hit_o  = 1'b1;
            byte_o = data_i[idx*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/store_queue.sv
// In-order store queue: multi-slot allocate, fill, multi-commit,
// single drain to the dcache and byte-granular load forwarding.
module store_queue
   import store_queue_pkg::*;
#(
   parameter int unsigned SQ_DEPTH     = 16,
   parameter int unsigned ALLOC_WIDTH  = 4,
   parameter int unsigned COMMIT_WIDTH = 4,
   parameter int unsigned IDW          = $clog2(SQ_DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [ALLOC_WIDTH-1:0]      alloc_req_i,
   input  logic                        alloc_fire_i,
   output logic                        alloc_ready_o,
   output logic [ALLOC_WIDTH*IDW-1:0]  alloc_id_o,
   input  logic                        ex_valid_i,
   input  logic [IDW-1:0]              ex_id_i,
   input  logic [PLEN-1:0]             ex_addr_i,
   input  logic [XLEN-1:0]             ex_data_i,
   input  lsu_op_e                     ex_op_i,
   input  logic [COMMIT_WIDTH-1:0]     commit_valid_i,
   input  logic [COMMIT_WIDTH*IDW-1:0] commit_id_i,
   output logic                        dcache_req_valid_o,
   input  logic                        dcache_req_ready_i,
   output logic [PLEN-1:0]             dcache_req_addr_o,
   output logic [XLEN-1:0]             dcache_req_data_o,
   output logic [NB-1:0]               dcache_req_be_o,
   input  logic                        load_valid_i,
   input  logic [PLEN-1:0]             load_addr_i,
   input  lsu_op_e                     load_op_i,
   output logic                        load_hit_o,
   output logic                        load_stall_o,
   output logic [XLEN-1:0]             load_data_o,
   input  logic                        flush_i,
   output logic [IDW:0]                count_o,
   output logic                        empty_o
);

   localparam logic [IDW:0] ONE = {{IDW{1'b0}}, 1'b1};

   sq_entry_t      ent_q [SQ_DEPTH];
   sq_entry_t      ent_d [SQ_DEPTH];
   sq_entry_t      head_e;
   logic [IDW-1:0] head_q, head_d;
   logic [IDW-1:0] tail_q, tail_d;
   logic [IDW:0]   cnt_q, cnt_d;
   logic [IDW:0]   pop, kept;
   logic [IDW+1:0] need;
   logic           fire, drain;

   always_comb begin
      pop        = '0;
      alloc_id_o = '0;
      for (int s = 0; s < ALLOC_WIDTH; s++) begin
         if (alloc_req_i[s]) begin
            alloc_id_o[s*IDW +: IDW] = tail_q + pop[IDW-1:0];
            pop = pop + ONE;
         end
      end
   end

   assign need          = {1'b0, cnt_q} + {1'b0, pop};
   assign alloc_ready_o = need <= (IDW+2)'(SQ_DEPTH);
   assign fire          = alloc_fire_i & alloc_ready_o & ~flush_i;

   assign head_e             = ent_q[head_q];
   assign dcache_req_valid_o = head_e.valid & head_e.committed
                             & head_e.ready;
   assign dcache_req_addr_o  = {head_e.waddr, {OFFW{1'b0}}};
   assign dcache_req_data_o  = head_e.data;
   assign dcache_req_be_o    = head_e.mask;
   assign drain = dcache_req_valid_o & dcache_req_ready_i;

   always_comb begin
      ent_d = ent_q;
      kept  = '0;
      for (int c = 0; c < COMMIT_WIDTH; c++) begin
         if (commit_valid_i[c]
             && ent_q[commit_id_i[c*IDW +: IDW]].valid)
            ent_d[commit_id_i[c*IDW +: IDW]].committed = 1'b1;
      end
      if (drain) begin
         ent_d[head_q].valid     = 1'b0;
         ent_d[head_q].committed = 1'b0;
      end
      if (flush_i) begin
         // committed entries form a contiguous run from head
         for (int e = 0; e < SQ_DEPTH; e++) begin
            if (ent_d[e].valid && ent_d[e].committed) begin
               kept = kept + ONE;
            end else begin
               ent_d[e].valid     = 1'b0;
               ent_d[e].committed = 1'b0;
            end
         end
      end else begin
         if (ex_valid_i && ent_q[ex_id_i].valid) begin
            ent_d[ex_id_i].ready = 1'b1;
            ent_d[ex_id_i].waddr = ex_addr_i[PLEN-1:OFFW];
            ent_d[ex_id_i].mask  =
               op_mask(ex_op_i, ex_addr_i[OFFW-1:0]);
            ent_d[ex_id_i].data  =
               ex_data_i << {ex_addr_i[OFFW-1:0], 3'b000};
         end
         if (fire) begin
            for (int s = 0; s < ALLOC_WIDTH; s++) begin
               if (alloc_req_i[s]) begin
                  ent_d[alloc_id_o[s*IDW +: IDW]]       = '0;
                  ent_d[alloc_id_o[s*IDW +: IDW]].valid = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      head_d = head_q + {{(IDW-1){1'b0}}, drain};
      if (flush_i) begin
         tail_d = head_d + kept[IDW-1:0];
         cnt_d  = kept;
      end else begin
         tail_d = tail_q + (fire ? pop[IDW-1:0] : '0);
         cnt_d  = cnt_q + (fire ? pop : '0)
                - {{IDW{1'b0}}, drain};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         for (int e = 0; e < SQ_DEPTH; e++)
            ent_q[e] <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         ent_q  <= ent_d;
      end
   end

   assign count_o = cnt_q;
   assign empty_o = (cnt_q == '0);

   logic [WAW-1:0]      ld_waddr;
   logic [NB-1:0]       ld_need, ld_sup, ld_got;
   logic [SQ_DEPTH-1:0] cand [NB];
   logic [SQ_DEPTH*8-1:0] bdat [NB];
   logic [7:0]          fbyte [NB];
   logic                ld_all, ld_any;

   assign ld_waddr = load_addr_i[PLEN-1:OFFW];
   assign ld_need  = op_mask(load_op_i, load_addr_i[OFFW-1:0]);

   always_comb begin
      for (int b = 0; b < NB; b++) begin
         cand[b] = '0;
         bdat[b] = '0;
         for (int e = 0; e < SQ_DEPTH; e++) begin
            cand[b][e] = ent_q[e].valid & ent_q[e].ready
                       & (ent_q[e].waddr == ld_waddr)
                       & ent_q[e].mask[b];
            bdat[b][e*8 +: 8] = ent_q[e].data[b*8 +: 8];
         end
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_fwd
      sq_byte_fwd #(
         .DEPTH (SQ_DEPTH),
         .IDW   (IDW)
      ) u_fwd (
         .head_i (head_q),
         .cand_i (cand[b]),
         .data_i (bdat[b]),
         .hit_o  (ld_sup[b]),
         .byte_o (fbyte[b])
      );
   end

   assign ld_got = ld_sup & ld_need;
   assign ld_all = (ld_got == ld_need);
   assign ld_any = |ld_got;

   assign load_hit_o   = load_valid_i & ld_all;
   assign load_stall_o = load_valid_i & ld_any & ~ld_all;

   always_comb begin
      load_data_o = '0;
      for (int b = 0; b < NB; b++) begin
         if (load_valid_i && ld_got[b])
            load_data_o[b*8 +: 8] = fbyte[b];
      end
   end

endmodule

// File: tb/tb_store_queue.sv
// Store queue bench: drain scoreboard filled at commit time,
// plus direct checks of alloc, forwarding, flush and reset.
module tb_store_queue;
   import store_queue_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic [3:0]  alloc_req_i;
   logic        alloc_fire_i;
   logic        alloc_ready_o;
   logic [15:0] alloc_id_o;
   logic        ex_valid_i;
   logic [3:0]  ex_id_i;
   logic [31:0] ex_addr_i;
   logic [63:0] ex_data_i;
   lsu_op_e     ex_op_i;
   logic [3:0]  commit_valid_i;
   logic [15:0] commit_id_i;
   logic        dcache_req_valid_o;
   logic        dcache_req_ready_i;
   logic [31:0] dcache_req_addr_o;
   logic [63:0] dcache_req_data_o;
   logic [7:0]  dcache_req_be_o;
   logic        load_valid_i;
   logic [31:0] load_addr_i;
   lsu_op_e     load_op_i;
   logic        load_hit_o;
   logic        load_stall_o;
   logic [63:0] load_data_o;
   logic        flush_i;
   logic [4:0]  count_o;
   logic        empty_o;

   always #5 clk_i = ~clk_i;

   store_queue #(
      .SQ_DEPTH     (16),
      .ALLOC_WIDTH  (4),
      .COMMIT_WIDTH (4)
   ) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .alloc_req_i        (alloc_req_i),
      .alloc_fire_i       (alloc_fire_i),
      .alloc_ready_o      (alloc_ready_o),
      .alloc_id_o         (alloc_id_o),
      .ex_valid_i         (ex_valid_i),
      .ex_id_i            (ex_id_i),
      .ex_addr_i          (ex_addr_i),
      .ex_data_i          (ex_data_i),
      .ex_op_i            (ex_op_i),
      .commit_valid_i     (commit_valid_i),
      .commit_id_i        (commit_id_i),
      .dcache_req_valid_o (dcache_req_valid_o),
      .dcache_req_ready_i (dcache_req_ready_i),
      .dcache_req_addr_o  (dcache_req_addr_o),
      .dcache_req_data_o  (dcache_req_data_o),
      .dcache_req_be_o    (dcache_req_be_o),
      .load_valid_i       (load_valid_i),
      .load_addr_i        (load_addr_i),
      .load_op_i          (load_op_i),
      .load_hit_o         (load_hit_o),
      .load_stall_o       (load_stall_o),
      .load_data_o        (load_data_o),
      .flush_i            (flush_i),
      .count_o            (count_o),
      .empty_o            (empty_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
   } drn_t;

   drn_t        exp_q[$];
   drn_t        mon_e;
   logic [31:0] m_addr [16];
   logic [63:0] m_data [16];
   logic [7:0]  m_be   [16];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          tb_tail;
   int          a_id [20];

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] be_of(input lsu_op_e op,
                                        input logic [2:0] off);
      int sz = 1 << op[1:0];
      return 8'(((1 << sz) - 1) << off);
   endfunction

   function automatic logic [63:0] lanes(input logic [7:0] be);
      logic [63:0] r = '0;
      for (int b = 0; b < 8; b++)
         if (be[b]) r[b*8 +: 8] = 8'hFF;
      return r;
   endfunction

   always @(negedge clk_i) begin
      if (rst_ni && dcache_req_valid_o && dcache_req_ready_i) begin
         if (exp_q.size() == 0) begin
            check("drain_unexpected", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("drain_addr", 64'(dcache_req_addr_o), 64'(mon_e.addr));
            check("drain_be", 64'(dcache_req_be_o), 64'(mon_e.be));
            check("drain_data", dcache_req_data_o & lanes(mon_e.be),
                  mon_e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      alloc_req_i = '0; alloc_fire_i = 1'b0;
      ex_valid_i = 1'b0; ex_id_i = '0; ex_addr_i = '0;
      ex_data_i = '0; ex_op_i = LSU_SB;
      commit_valid_i = '0; commit_id_i = '0;
      load_valid_i = 1'b0; load_addr_i = '0; load_op_i = LSU_LB;
      flush_i = 1'b0;
   endtask

   task automatic set_fill(input int id, input lsu_op_e op,
                           input logic [31:0] a, input logic [63:0] d);
      logic [7:0] be;
      be = be_of(op, a[2:0]);
      ex_valid_i = 1'b1; ex_id_i = 4'(id);
      ex_op_i = op; ex_addr_i = a; ex_data_i = d;
      m_addr[id] = {a[31:3], 3'b000};
      m_be[id]   = be;
      m_data[id] = (d << (a[2:0] * 8)) & lanes(be);
   endtask

   task automatic fill(input int id, input lsu_op_e op,
                       input logic [31:0] a, input logic [63:0] d);
      set_fill(id, op, a, d);
      tick();
      ex_valid_i = 1'b0;
   endtask

   task automatic set_commit(input int slot, input int id);
      drn_t e;
      e.addr = m_addr[id]; e.data = m_data[id]; e.be = m_be[id];
      exp_q.push_back(e);
      commit_valid_i[slot] = 1'b1;
      commit_id_i[slot*4 +: 4] = 4'(id);
   endtask

   task automatic probe(input string tag, input logic lv,
                        input lsu_op_e op, input logic [31:0] a,
                        input logic eh, input logic es,
                        input logic [63:0] ed);
      load_valid_i = lv; load_op_i = op; load_addr_i = a;
      #1;
      check({tag, "_hit"}, 64'(load_hit_o), 64'(eh));
      check({tag, "_stall"}, 64'(load_stall_o), 64'(es));
      check({tag, "_data"}, load_data_o, ed);
      load_valid_i = 1'b0;
   endtask

   task automatic wait_empty(input string tag, input int budget);
      int n = 0;
      while (!empty_o && n < budget) begin
         tick();
         n++;
      end
      check(tag, 64'(empty_o), 64'd1);
   endtask

   function automatic logic [15:0] ids4(input int base,
                                        input logic [3:0] req);
      logic [15:0] r = '0;
      int k = 0;
      for (int s = 0; s < 4; s++) begin
         if (req[s]) begin
            r[s*4 +: 4] = 4'((base + k) % 16);
            k++;
         end
      end
      return r;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      dcache_req_ready_i = 1'b0;
      #1 rst_ni = 1'b0;
      #11;
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_empty", 64'(empty_o), 64'd1);
      check("rst_dvalid", 64'(dcache_req_valid_o), 64'd0);
      check("rst_hit", 64'(load_hit_o), 64'd0);
      check("rst_stall", 64'(load_stall_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();

      // allocation id assignment
      alloc_req_i = 4'b1111; alloc_fire_i = 1'b1;
      #1;
      check("alloc4_rdy", 64'(alloc_ready_o), 64'd1);
      check("alloc4_ids", 64'(alloc_id_o), 64'h3210);
      tick();
      alloc_req_i = 4'b1010;
      #1;
      check("alloc4_cnt", 64'(count_o), 64'd4);
      check("alloc_sparse_ids", 64'(alloc_id_o), 64'h5040);
      tick();
      alloc_req_i = '0; alloc_fire_i = 1'b0;
      check("alloc_cnt6", 64'(count_o), 64'd6);
      probe("ld_notready", 1'b1, LSU_LW, 32'h1000, 1'b0, 1'b0, 64'h0);

      // forwarding merge, partial stall, misses
      fill(0, LSU_SW, 32'h1000, 64'hAABBCCDD);
      fill(1, LSU_SB, 32'h1001, 64'h11);
      fill(2, LSU_SB, 32'h2000, 64'h55);
      probe("ld_merge", 1'b1, LSU_LW, 32'h1000, 1'b1, 1'b0,
            64'hAABB11DD);
      probe("ld_byte", 1'b1, LSU_LB, 32'h1001, 1'b1, 1'b0,
            64'h1100);
      probe("ld_partial", 1'b1, LSU_LD, 32'h1000, 1'b0, 1'b1,
            64'hAABB11DD);
      probe("ld_sb_only", 1'b1, LSU_LW, 32'h2000, 1'b0, 1'b1,
            64'h55);
      probe("ld_miss", 1'b1, LSU_LW, 32'h1004, 1'b0, 1'b0, 64'h0);
      probe("ld_novalid", 1'b0, LSU_LW, 32'h1000, 1'b0, 1'b0, 64'h0);

      // flush with same-cycle commit of id0; alloc and fill ignored
      flush_i = 1'b1;
      set_commit(0, 0);
      alloc_req_i = 4'b0001; alloc_fire_i = 1'b1;
      set_fill(3, LSU_SW, 32'h7000, 64'h77);
      tick();
      idle();
      check("flush_cnt", 64'(count_o), 64'd1);
      check("flush_dvalid", 64'(dcache_req_valid_o), 64'd1);
      alloc_req_i = 4'b0001;
      #1;
      check("flush_tail", 64'(alloc_id_o), 64'h1);
      alloc_req_i = '0;
      probe("ld_flushed", 1'b1, LSU_LW, 32'h2000, 1'b0, 1'b0, 64'h0);
      dcache_req_ready_i = 1'b1;
      wait_empty("flush_drain_done", 20);
      dcache_req_ready_i = 1'b0;
      tb_tail = 1;

      // fill to full, back-pressure, then one drain per cycle
      for (int c = 0; c < 4; c++) begin
         alloc_req_i = 4'b1111; alloc_fire_i = 1'b1;
         #1;
         check("full_ids", 64'(alloc_id_o), 64'(ids4(tb_tail, 4'hF)));
         tick();
         tb_tail = (tb_tail + 4) % 16;
      end
      alloc_req_i = 4'b0001; alloc_fire_i = 1'b0;
      #1;
      check("full_cnt", 64'(count_o), 64'd16);
      check("full_rdy", 64'(alloc_ready_o), 64'd0);
      alloc_req_i = 4'b0000;
      #1;
      check("full_rdy_noreq", 64'(alloc_ready_o), 64'd1);
      alloc_req_i = 4'b0001; alloc_fire_i = 1'b1;
      tick();
      alloc_req_i = '0; alloc_fire_i = 1'b0;
      check("full_cnt_hold", 64'(count_o), 64'd16);
      for (int k = 0; k < 16; k++) begin
         int sz = 1 << (k % 4);
         int off = ((k / 4) * sz) % 8;
         fill((1 + k) % 16, lsu_op_e'(3'(4 + k % 4)),
              32'h3000 + 32'(k * 8 + off),
              64'hF0E1D2C3B4A59687 ^ (64'(k) * 64'h0101));
      end
      for (int c = 0; c < 4; c++) begin
         commit_valid_i = '0;
         for (int s = 0; s < 4; s++)
            set_commit(s, (1 + c * 4 + s) % 16);
         tick();
      end
      idle();
      for (int n = 0; n < 5; n++) begin
         check("stall_valid", 64'(dcache_req_valid_o), 64'd1);
         check("stall_addr", 64'(dcache_req_addr_o),
               64'(exp_q[0].addr));
         check("stall_be", 64'(dcache_req_be_o), 64'(exp_q[0].be));
         tick();
      end
      dcache_req_ready_i = 1'b1;
      tick();
      check("one_drain", 64'(count_o), 64'd15);
      tick();
      check("two_drain", 64'(count_o), 64'd14);
      wait_empty("full_drain_done", 30);

      // streaming across the wrap with youngest-wins forwarding
      for (int i = 0; i < 20; i++) begin
         a_id[i] = (tb_tail + i) % 16;
         commit_valid_i = '0;
         ex_valid_i = 1'b0;
         alloc_req_i = 4'b0001; alloc_fire_i = 1'b1;
         if (i >= 1)
            set_fill(a_id[i-1], LSU_SW, 32'h5000, 64'(32'h100 + i - 1));
         if (i >= 3)
            set_commit(0, a_id[i-3]);
         load_valid_i = 1'b1; load_op_i = LSU_LW;
         load_addr_i = 32'h5000;
         #1;
         check("wrap_id", 64'(alloc_id_o[3:0]), 64'(a_id[i]));
         if (i >= 2) begin
            check("wrap_fwd_hit", 64'(load_hit_o), 64'd1);
            check("wrap_fwd_data", load_data_o, 64'(32'h100 + i - 2));
         end
         tick();
      end
      idle();
      set_fill(a_id[19], LSU_SW, 32'h5000, 64'h113);
      set_commit(0, a_id[17]);
      tick();
      idle();
      set_commit(0, a_id[18]);
      tick();
      idle();
      set_commit(0, a_id[19]);
      tick();
      idle();
      wait_empty("wrap_drain_done", 30);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      tb_tail = (tb_tail + 20) % 16;

      // reset while a drain request is pending
      dcache_req_ready_i = 1'b0;
      alloc_req_i = 4'b0001; alloc_fire_i = 1'b1;
      tick();
      idle();
      fill(tb_tail, LSU_SD, 32'h6000, 64'h0123456789ABCDEF);
      set_commit(0, tb_tail);
      tick();
      idle();
      check("pre_rst_dvalid", 64'(dcache_req_valid_o), 64'd1);
      probe("pre_rst_ld", 1'b1, LSU_LD, 32'h6000, 1'b1, 1'b0,
            64'h0123456789ABCDEF);
      load_valid_i = 1'b1;
      #2 rst_ni = 1'b0;
      #1;
      exp_q.delete();
      check("mid_rst_dvalid", 64'(dcache_req_valid_o), 64'd0);
      check("mid_rst_count", 64'(count_o), 64'd0);
      check("mid_rst_empty", 64'(empty_o), 64'd1);
      check("mid_rst_hit", 64'(load_hit_o), 64'd0);
      check("mid_rst_stall", 64'(load_stall_o), 64'd0);
      load_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter SQ_DEPTH, default 16, entry count; power of two, >=4.
REQ-002 Parameter ALLOC_WIDTH, default 4, dispatch slots per cycle.
REQ-003 Parameter COMMIT_WIDTH, default 4, retire slots per cycle.
REQ-004 Parameter IDW, default $clog2(SQ_DEPTH), entry-id width.
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 alloc_req_i  in  ALLOC_WIDTH  per-slot store allocation request.
REQ-008 alloc_fire_i  in  1  upstream commits the allocation this cycle.
REQ-009 alloc_ready_o  out  1  all requested slots fit this cycle.
REQ-010 alloc_id_o  out  ALLOC_WIDTH x IDW  entry id per requesting slot, 0 otherwise.
REQ-011 ex_valid_i / ex_id_i / ex_addr_i / ex_data_i / ex_op_i  in  1 / IDW / PLEN / XLEN / lsu_op_e  address+data fill.
REQ-012 commit_valid_i / commit_id_i  in  COMMIT_WIDTH / COMMIT_WIDTH x IDW  retire marks.
REQ-013 dcache_req_valid_o / dcache_req_ready_i  out / in  1 / 1  drain handshake.
REQ-014 dcache_req_addr_o / dcache_req_data_o / dcache_req_be_o  out  PLEN / XLEN / XLEN/8  word-aligned address, lane-aligned data, byte enables.
REQ-015 load_valid_i / load_addr_i / load_op_i  in  1 / PLEN / lsu_op_e  forwarding probe.
REQ-016 load_hit_o / load_stall_o / load_data_o  out  1 / 1 / XLEN  full forward, must-retry, lane-aligned merged data.
REQ-017 flush_i  in  1  squash speculative entries.
REQ-018 count_o / empty_o  out  IDW+1 / 1  occupancy; high when count_o==0.

Function
REQ-019 Circular queue; head = oldest, tail = next free; count width IDW+1, ptrs wrap modulo SQ_DEPTH.
REQ-020 alloc_ready_o = (count + popcount(alloc_req_i) <= SQ_DEPTH), combinational, independent of alloc_fire_i.
REQ-021 Ids assigned in slot order, compacted: k-th requesting slot gets tail+k.
REQ-022 Allocation when alloc_fire_i & alloc_ready_o: entries valid=1, committed=0, addr/data_valid=0; tail advances by popcount.
REQ-023 Entry state per id: valid, committed, ready(addr+data), word address, byte mask, lane data.
REQ-024 ex fill sets ready=1, mask = size(B=1,H=2,W=4,D=8 bytes) shifted by addr[log2(XLEN/8)-1:0], data shifted into lanes; misaligned ops undefined.
REQ-025 Commit marks committed=1 next cycle; multiple commits per cycle; commit of non-valid id ignored.
REQ-026 dcache_req_valid_o = head valid & committed & ready; outputs drive head fields; held stable until ready.
REQ-027 Drain fire (valid & ready) frees head, head+1, count-1, next cycle; at most one drain per cycle.
REQ-028 Simultaneous alloc+drain: count += alloc - 1; alloc+fill+commit+drain on distinct ids all take effect same cycle.
REQ-029 Forward: per load byte, youngest valid ready entry with equal word address and that mask bit supplies it; search tail-1 down to head.
REQ-030 load_hit_o = load_valid_i & every load byte supplied; load_data_o carries merged bytes, zero in unsupplied lanes.
REQ-031 load_stall_o = load_valid_i & (some but not all bytes supplied, or any word-address match on entry with ready=0 from addr fill pending data -- n/a: ready is atomic, so stall only on partial).
REQ-032 Entries with ready=0 ignored by forwarding; load_hit_o and load_stall_o mutually exclusive; all zero when !load_valid_i.
REQ-033 Flush: keep entries committed or committed this cycle; invalidate rest; tail = head + kept; count = kept; alloc and fill ignored; drain still fires.
REQ-034 Full: no allocation; empty: dcache_req_valid_o=0.

Reset
REQ-035 On rst_ni low: head=tail=0, count_o=0, empty_o=1, all entries invalid, dcache_req_valid_o=0, load_hit_o=load_stall_o=0; reset mid-drain abandons request.

Structure
REQ-036 sq_entry_t and op-to-size function live in decode_pkg; PLEN/XLEN from config_pkg Cfg.
REQ-037 One sub-module sq_byte_fwd: per-byte youngest-match priority select across entries.

Verification
REQ-038 Alloc 4 stores on empty SQ_DEPTH=16 -> ids 0..3, count_o=4; alloc req 0b1010 -> ids slot1=4, slot3=5.
REQ-039 SW 0x1000=0xAABBCCDD, SB 0x1001=0x11, load LW 0x1000 -> hit, data 0xAABB11DD (lanes).
REQ-040 SB 0x2000 only, load LW 0x2000 -> load_stall_o=1, load_hit_o=0.
REQ-041 3 entries, commit id0 same cycle as flush -> count_o=1, tail=head+1, id0 drains with be per its op.
REQ-042 Fill to 16, alloc 1 -> alloc_ready_o=0; drain with ready stuck low 5 cycles -> outputs stable, then single drain per cycle.
REQ-043 Wrap: 20 alloc/commit/drain cycles with depth 16 -> ids wrap 15->0, forwarding picks youngest across wrap.
